// File: rtl/riscv_pkg.sv
// Shared RV32 memory-stage definitions: load/store funct3 codes, MEM FSM states
// and the access legality check used by the memory stage.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_RSP = 1'b1
   } mem_state_t;

   // Unsigned widths exist only for loads; a read+write combination is never legal.
   function automatic logic access_legal(input logic rd_en, input logic wr_en,
                                         input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic ok;
      ok = 1'b0;
      case (funct3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~addr_lo[0];
         F3_W:    ok = (addr_lo == 2'b00);
         F3_BU:   ok = rd_en;
         F3_HU:   ok = rd_en & ~addr_lo[0];
         default: ok = 1'b0;
      endcase
      return ok & ~(rd_en & wr_en);
   endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a load response word and
// sign- or zero-extends it according to funct3.
module load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = rdata[7:0];
      case (addr_lo)
         2'd0: lane_b = rdata[7:0];
         2'd1: lane_b = rdata[15:8];
         2'd2: lane_b = rdata[23:16];
         2'd3: lane_b = rdata[31:24];
         default: lane_b = rdata[7:0];
      endcase
      lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data = 32'h0;
      case (funct3)
         F3_B:    data = {{24{lane_b[7]}}, lane_b};
         F3_BU:   data = {24'h0, lane_b};
         F3_H:    data = {{16{lane_h[15]}}, lane_h};
         F3_HU:   data = {16'h0, lane_h};
         F3_W:    data = rdata;
         default: data = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// RV32 MEM stage: issues data-memory requests, stalls upstream while waiting,
// and registers the MEM/WB results.
//   state    | meaning
//   IDLE     | accepting a new EX/MEM slot; stores and non-memory ops finish here
//   WAIT_RSP | load accepted by memory, waiting for dmem_rsp_valid
module mem_access
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] store_data_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic        regwrite_i,
   input  logic        mem_to_reg_i,
   input  logic [2:0]  funct3_i,
   input  logic [4:0]  rd_i,
   output logic        stall_o,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic [31:0] dmem_addr,
   output logic        dmem_we,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [31:0] alu_result_o,
   output logic [31:0] ld_data_o,
   output logic        mem_to_reg_o,
   output logic [4:0]  rd_o,
   output logic        regwrite_o,
   output logic        mem_exc_o
);

   mem_state_t  state;
   logic        is_mem;
   logic        legal;
   logic        issue;
   logic        exc;
   logic        complete;
   logic        load_done;
   logic [31:0] ld_data;

   assign is_mem    = mem_read_i | mem_write_i;
   assign legal     = access_legal(mem_read_i, mem_write_i, funct3_i, alu_result_i[1:0]);
   assign issue     = (state == IDLE) & in_valid & is_mem & legal;
   assign exc       = (state == IDLE) & is_mem & ~legal;
   assign load_done = (state == WAIT_RSP) & dmem_rsp_valid;
   assign complete  = ((state == IDLE) & in_valid &
                       (~is_mem | ~legal | (mem_write_i & dmem_req_ready))) | load_done;

   // Upstream holds the slot while stalled, so request fields come straight from inputs.
   always_comb begin
      dmem_req_valid = issue;
      dmem_addr      = {alu_result_i[31:2], 2'b00};
      dmem_we        = issue & mem_write_i;
      dmem_wstrb     = 4'b0000;
      dmem_wdata     = store_data_i;
      if (issue & mem_write_i) begin
         case (funct3_i)
            F3_B: begin
               dmem_wstrb = 4'b0001 << alu_result_i[1:0];
               dmem_wdata = {4{store_data_i[7:0]}};
            end
            F3_H: begin
               dmem_wstrb = 4'b0011 << {alu_result_i[1], 1'b0};
               dmem_wdata = {2{store_data_i[15:0]}};
            end
            default: dmem_wstrb = 4'b1111;
         endcase
      end
   end

   always_comb begin
      stall_o = 1'b0;
      if (state == WAIT_RSP) stall_o = ~dmem_rsp_valid;
      else                   stall_o = issue & (mem_read_i | ~dmem_req_ready);
   end

   load_align u_load_align (
      .rdata   (dmem_rdata),
      .addr_lo (alu_result_i[1:0]),
      .funct3  (funct3_i),
      .data    (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         wb_valid     <= 1'b0;
         alu_result_o <= 32'h0;
         ld_data_o    <= 32'h0;
         mem_to_reg_o <= 1'b0;
         rd_o         <= 5'd0;
         regwrite_o   <= 1'b0;
         mem_exc_o    <= 1'b0;
      end else begin
         case (state)
            IDLE:     if (issue & mem_read_i & dmem_req_ready) state <= WAIT_RSP;
            WAIT_RSP: if (dmem_rsp_valid) state <= IDLE;
            default:  state <= IDLE;
         endcase

         wb_valid   <= complete;
         regwrite_o <= complete & regwrite_i & (rd_i != 5'd0) & ~exc & ~mem_write_i;
         mem_exc_o  <= complete & exc;
         if (complete) begin
            alu_result_o <= alu_result_i;
            rd_o         <= rd_i;
            mem_to_reg_o <= mem_to_reg_i & ~exc;
            ld_data_o    <= load_done ? ld_data : 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: single-cycle vector table plus hand-written
// load, stalled-store and reset-in-WAIT_RSP sequences.
module tb_mem_access;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] alu_result_i;
   logic [31:0] store_data_i;
   logic        mem_read_i, mem_write_i, regwrite_i, mem_to_reg_i;
   logic [2:0]  funct3_i;
   logic [4:0]  rd_i;
   logic        stall_o;
   logic        dmem_req_valid, dmem_req_ready;
   logic [31:0] dmem_addr;
   logic        dmem_we;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic [31:0] alu_result_o, ld_data_o;
   logic        mem_to_reg_o;
   logic [4:0]  rd_o;
   logic        regwrite_o, mem_exc_o;

   int checks = 0;
   int errors = 0;

   mem_access dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .alu_result_i(alu_result_i), .store_data_i(store_data_i),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .regwrite_i(regwrite_i), .mem_to_reg_i(mem_to_reg_i),
      .funct3_i(funct3_i), .rd_i(rd_i), .stall_o(stall_o),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
      .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
      .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
      .alu_result_o(alu_result_o), .ld_data_o(ld_data_o),
      .mem_to_reg_o(mem_to_reg_o), .rd_o(rd_o),
      .regwrite_o(regwrite_o), .mem_exc_o(mem_exc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        iv, rd_en, wr_en, rw, mtr;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] alu, sd;
      logic        ready;
      logic        e_req, e_stall;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic        e_wb, e_rw, e_exc;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; mem_read_i = 0; mem_write_i = 0; regwrite_i = 0;
      mem_to_reg_i = 0; funct3_i = 0; rd_i = 0; alu_result_i = 0;
      store_data_i = 0; dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
   endtask

   task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input int delay, input logic [31:0] rdata, input logic [31:0] exp);
      in_valid = 1; mem_read_i = 1; mem_write_i = 0; regwrite_i = 1; mem_to_reg_i = 1;
      funct3_i = f3; rd_i = 5'd7; alu_result_i = addr; dmem_req_ready = 1; dmem_rsp_valid = 0;
      #1;
      chk({name, " req_valid"}, 32'(dmem_req_valid), 32'd1);
      chk({name, " addr"}, dmem_addr, {addr[31:2], 2'b00});
      chk({name, " we"}, 32'(dmem_we), 32'd0);
      chk({name, " stall accept"}, 32'(stall_o), 32'd1);
      step();
      chk({name, " wb bubble"}, 32'(wb_valid), 32'd0);
      chk({name, " req in wait"}, 32'(dmem_req_valid), 32'd0);
      for (int i = 0; i < delay; i++) begin
         chk({name, " stall wait"}, 32'(stall_o), 32'd1);
         step();
         chk({name, " wb wait"}, 32'(wb_valid), 32'd0);
      end
      dmem_rsp_valid = 1; dmem_rdata = rdata;
      #1;
      chk({name, " stall rsp"}, 32'(stall_o), 32'd0);
      step();
      idle_inputs();
      chk({name, " wb_valid"}, 32'(wb_valid), 32'd1);
      chk({name, " ld_data"}, ld_data_o, exp);
      chk({name, " regwrite"}, 32'(regwrite_o), 32'd1);
      chk({name, " mem_to_reg"}, 32'(mem_to_reg_o), 32'd1);
      chk({name, " rd"}, 32'(rd_o), 32'd7);
   endtask

   initial begin
      //         iv rd wr rw mt f3      rd     alu           sd            rdy req stl strb     wdata         wb rw ex
      vecs[0]  = '{1, 0, 0, 1, 0, 3'b000, 5'd5, 32'h00000010, 32'h0,        1, 0, 0, 4'h0,    32'h0,        1, 1, 0};
      vecs[1]  = '{1, 0, 1, 0, 0, 3'b000, 5'd0, 32'h00000101, 32'h000000A5, 1, 1, 0, 4'b0010, 32'hA5A5A5A5, 1, 0, 0};
      vecs[2]  = '{1, 0, 1, 0, 0, 3'b010, 5'd0, 32'h00000200, 32'hDEADBEEF, 1, 1, 0, 4'b1111, 32'hDEADBEEF, 1, 0, 0};
      vecs[3]  = '{1, 0, 1, 0, 0, 3'b001, 5'd0, 32'h00000200, 32'h1234ABCD, 1, 1, 0, 4'b0011, 32'hABCDABCD, 1, 0, 0};
      vecs[4]  = '{1, 1, 0, 1, 1, 3'b010, 5'd3, 32'h00000301, 32'h0,        1, 0, 0, 4'h0,    32'h0,        1, 0, 1};
      vecs[5]  = '{1, 1, 0, 1, 1, 3'b001, 5'd3, 32'h00000303, 32'h0,        1, 0, 0, 4'h0,    32'h0,        1, 0, 1};
      vecs[6]  = '{1, 0, 1, 0, 0, 3'b010, 5'd0, 32'h00000302, 32'h0,        1, 0, 0, 4'h0,    32'h0,        1, 0, 1};
      vecs[7]  = '{1, 1, 0, 1, 1, 3'b011, 5'd3, 32'h00000300, 32'h0,        1, 0, 0, 4'h0,    32'h0,        1, 0, 1};
      vecs[8]  = '{1, 0, 1, 0, 0, 3'b100, 5'd0, 32'h00000300, 32'h0,        1, 0, 0, 4'h0,    32'h0,        1, 0, 1};
      vecs[9]  = '{1, 1, 1, 1, 0, 3'b010, 5'd3, 32'h00000300, 32'h0,        1, 0, 0, 4'h0,    32'h0,        1, 0, 1};
      vecs[10] = '{1, 0, 0, 1, 0, 3'b000, 5'd0, 32'h00000044, 32'h0,        1, 0, 0, 4'h0,    32'h0,        1, 0, 0};
      vecs[11] = '{0, 0, 0, 1, 0, 3'b000, 5'd9, 32'h00000055, 32'h0,        1, 0, 0, 4'h0,    32'h0,        0, 0, 0};
      vecs[12] = '{1, 0, 1, 0, 0, 3'b000, 5'd0, 32'h00000103, 32'h12345677, 1, 1, 0, 4'b1000, 32'h77777777, 1, 0, 0};

      idle_inputs();
      rst_n = 0;
      #12;
      chk("reset outputs", {wb_valid, regwrite_o, mem_exc_o, mem_to_reg_o, rd_o}, 32'h0);
      chk("reset alu_result", alu_result_o, 32'h0);
      chk("reset ld_data", ld_data_o, 32'h0);
      chk("reset stall", 32'(stall_o), 32'd0);
      rst_n = 1;
      step();

      for (int i = 0; i < 13; i++) begin
         in_valid = vecs[i].iv; mem_read_i = vecs[i].rd_en; mem_write_i = vecs[i].wr_en;
         regwrite_i = vecs[i].rw; mem_to_reg_i = vecs[i].mtr; funct3_i = vecs[i].f3;
         rd_i = vecs[i].rd; alu_result_i = vecs[i].alu; store_data_i = vecs[i].sd;
         dmem_req_ready = vecs[i].ready;
         #1;
         chk($sformatf("vec%0d req_valid", i), 32'(dmem_req_valid), 32'(vecs[i].e_req));
         chk($sformatf("vec%0d stall", i), 32'(stall_o), 32'(vecs[i].e_stall));
         if (vecs[i].e_req) begin
            chk($sformatf("vec%0d wstrb", i), 32'(dmem_wstrb), 32'(vecs[i].e_strb));
            chk($sformatf("vec%0d wdata", i), dmem_wdata, vecs[i].e_wdata);
            chk($sformatf("vec%0d we", i), 32'(dmem_we), 32'd1);
         end
         step();
         chk($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wb));
         chk($sformatf("vec%0d regwrite", i), 32'(regwrite_o), 32'(vecs[i].e_rw));
         chk($sformatf("vec%0d mem_exc", i), 32'(mem_exc_o), 32'(vecs[i].e_exc));
         if (vecs[i].e_wb) begin
            chk($sformatf("vec%0d alu_result", i), alu_result_o, vecs[i].alu);
            chk($sformatf("vec%0d rd", i), 32'(rd_o), 32'(vecs[i].rd));
            chk($sformatf("vec%0d ld_data", i), ld_data_o, 32'h0);
         end
      end
      idle_inputs();
      step();

      do_load("lb", 3'b000, 32'h00000103, 0, 32'h80FF0000, 32'hFFFFFF80);
      do_load("lhu", 3'b101, 32'h00000400, 4, 32'h0000F00F, 32'h0000F00F);
      do_load("lh", 3'b001, 32'h00000402, 1, 32'h80011234, 32'hFFFF8001);
      do_load("lbu", 3'b100, 32'h00000401, 0, 32'h00009A00, 32'h0000009A);
      do_load("lw", 3'b010, 32'h00000500, 2, 32'hCAFEF00D, 32'hCAFEF00D);

      // store held off by ready for three cycles
      in_valid = 1; mem_write_i = 1; funct3_i = 3'b001; alu_result_i = 32'h00000202;
      store_data_i = 32'h1234ABCD; rd_i = 5'd4; regwrite_i = 1; dmem_req_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("sh stall", 32'(stall_o), 32'd1);
         chk("sh req_valid", 32'(dmem_req_valid), 32'd1);
         chk("sh addr", dmem_addr, 32'h00000200);
         chk("sh wstrb", 32'(dmem_wstrb), 32'b1100);
         chk("sh wdata", dmem_wdata, 32'hABCDABCD);
         step();
         chk("sh wb wait", 32'(wb_valid), 32'd0);
      end
      dmem_req_ready = 1;
      #1;
      chk("sh stall accept", 32'(stall_o), 32'd0);
      chk("sh wstrb accept", 32'(dmem_wstrb), 32'b1100);
      step();
      idle_inputs();
      chk("sh wb_valid", 32'(wb_valid), 32'd1);
      chk("sh regwrite", 32'(regwrite_o), 32'd0);

      // response while IDLE must be ignored
      dmem_rsp_valid = 1; dmem_rdata = 32'h11111111;
      step();
      chk("idle rsp wb", 32'(wb_valid), 32'd0);
      dmem_rsp_valid = 0;

      // reset while waiting for a load response
      in_valid = 1; mem_read_i = 1; regwrite_i = 1; mem_to_reg_i = 1; funct3_i = 3'b010;
      rd_i = 5'd8; alu_result_i = 32'h00000600; dmem_req_ready = 1;
      step();
      chk("rst load wait stall", 32'(stall_o), 32'd1);
      idle_inputs();
      #2 rst_n = 0;
      #1;
      chk("rst wait outputs", {wb_valid, regwrite_o, mem_exc_o, mem_to_reg_o, rd_o}, 32'h0);
      chk("rst wait alu_result", alu_result_o, 32'h0);
      chk("rst wait ld_data", ld_data_o, 32'h0);
      #2 rst_n = 1;
      dmem_rsp_valid = 1; dmem_rdata = 32'h22222222;
      step();
      chk("late rsp wb", 32'(wb_valid), 32'd0);
      chk("late rsp ld_data", ld_data_o, 32'h0);
      step();
      chk("late rsp wb 2", 32'(wb_valid), 32'd0);
      dmem_rsp_valid = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
